demux_rr_lanes: RTL and testbench

Parametrised 1-to-N round-robin byte-lane demultiplexer for the PHY receive path. It is the generalised successor to the fixed two-lane demux. A serial stream of W-bit words qualified by `valid_in` is distributed across N output lanes. It runs in one of two modes:

- **Lane mode:** each lane updates on its own slot.
- **Frame mode:** N words are gathered and presented together.

Both modes support a flush for partial frames and a running frame counter.

---
 rtl/phy_pkg.sv | 26 ++
 rtl/rr_lane_ptr.sv | 27 ++
 rtl/demux_rr_lanes.sv | 124 ++++++++++++
 tb/tb_demux_rr_lanes.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the PHY receive path: mode selectors and small
// elaboration helpers used by the lane demux and the future lane mux.
package phy_pkg;

    localparam int DEMUX_LANE_MODE  = 0;
    localparam int DEMUX_FRAME_MODE = 1;

    // Ceiling log2, used to size lane pointers (N is always >= 2 here).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Low bit index of lane `lane` inside a packed bus of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/rr_lane_ptr.sv
// Round-robin lane pointer: a modulo-N counter shared by the demux and mux
// sides. A clear wins over an increment so a flush always realigns to lane 0.
module rr_lane_ptr
    import phy_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    // N is a power of two, so natural binary wrap gives modulo-N counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/demux_rr_lanes.sv
// 1-to-N round-robin word demultiplexer. Lane mode writes each word straight
// to its lane; frame mode gathers N words in staging registers and emits them
// together, with flush emitting whatever partial frame has been gathered.
module demux_rr_lanes
    import phy_pkg::*;
#(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int MODE = 0,
    parameter int CW   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   data_in,
    input  logic           valid_in,
    input  logic           flush,
    output logic [N*W-1:0] data_out,
    output logic [N-1:0]   valid_out,
    output logic [CW-1:0]  frame_cnt
);

    localparam int PW = clog2(N);

    // Frames always start at lane 0, so the pointer doubles as the fill count
    // of the current frame.
    logic [PW-1:0] ptr;

    rr_lane_ptr #(.N(N)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (valid_in),
        .clr   (flush),
        .ptr   (ptr)
    );

    if (MODE == DEMUX_LANE_MODE) begin : g_lane

        logic [PW-1:0] post_ptr;
        logic          frame_done;

        // A frame ends when lane N-1 is written, or when a flush abandons a
        // frame that still has words in it after this cycle's accept.
        always_comb begin
            post_ptr   = ptr + PW'(valid_in);
            frame_done = (valid_in && (ptr == PW'(N - 1))) ||
                         (flush && (post_ptr != '0));
        end

        // Each accepted word goes straight to its lane with a one-cycle valid.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_out  <= '0;
                valid_out <= '0;
                frame_cnt <= '0;
            end else begin
                valid_out <= '0;
                if (valid_in) begin
                    data_out[lane_lo(int'(ptr), W) +: W] <= data_in;
                    valid_out[ptr] <= 1'b1;
                end
                if (frame_done) begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end

    end else begin : g_frame

        logic [W-1:0]  stage [N];
        logic [PW:0]   post_k;
        logic          last_word;
        logic          emit_partial;

        // post_k is the fill count after this cycle's word; a word that
        // completes the frame takes precedence over a simultaneous flush.
        always_comb begin
            post_k       = {1'b0, ptr} + (PW + 1)'(valid_in);
            last_word    = valid_in && (ptr == PW'(N - 1));
            emit_partial = flush && !last_word && (post_k != '0);
        end

        // Staging keeps its contents across emits; only reset clears it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int j = 0; j < N; j++) begin
                    stage[j] <= '0;
                end
            end else if (valid_in) begin
                stage[ptr] <= data_in;
            end
        end

        // Emit a full frame or a flushed partial; the word arriving this
        // cycle is not yet in staging, so it is bypassed from data_in.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_out  <= '0;
                valid_out <= '0;
                frame_cnt <= '0;
            end else begin
                valid_out <= '0;
                if (last_word) begin
                    for (int j = 0; j < N - 1; j++) begin
                        data_out[lane_lo(j, W) +: W] <= stage[j];
                    end
                    data_out[lane_lo(N - 1, W) +: W] <= data_in;
                    valid_out <= '1;
                    frame_cnt <= frame_cnt + CW'(1);
                end else if (emit_partial) begin
                    for (int j = 0; j < N; j++) begin
                        if ((PW + 1)'(j) < post_k) begin
                            data_out[lane_lo(j, W) +: W] <=
                                (valid_in && (ptr == PW'(j))) ? data_in : stage[j];
                            valid_out[j] <= 1'b1;
                        end
                    end
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end

    end

endmodule

// File: tb/tb_demux_rr_lanes.sv
// Directed bench for demux_rr_lanes: a lane-mode instance, a frame-mode
// instance and a frame-mode instance with a 4-bit frame counter, all fed the
// same word stream and checked against hand-computed values.
module tb_demux_rr_lanes;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [W-1:0]   data_in;
    logic           valid_in;
    logic           flush;

    logic [N*W-1:0] lane_data;
    logic [N-1:0]   lane_valid;
    logic [15:0]    lane_cnt;

    logic [N*W-1:0] frame_data;
    logic [N-1:0]   frame_valid;
    logic [15:0]    frame_cnt;

    logic [N*W-1:0] wrap_data;
    logic [N-1:0]   wrap_valid;
    logic [3:0]     wrap_cnt;

    int checks;
    int fails;

    demux_rr_lanes #(.W(W), .N(N), .MODE(0), .CW(16)) dut_lane (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .flush     (flush),
        .data_out  (lane_data),
        .valid_out (lane_valid),
        .frame_cnt (lane_cnt)
    );

    demux_rr_lanes #(.W(W), .N(N), .MODE(1), .CW(16)) dut_frame (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .flush     (flush),
        .data_out  (frame_data),
        .valid_out (frame_valid),
        .frame_cnt (frame_cnt)
    );

    demux_rr_lanes #(.W(W), .N(N), .MODE(1), .CW(4)) dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .flush     (flush),
        .data_out  (wrap_data),
        .valid_out (wrap_valid),
        .frame_cnt (wrap_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; returns just after the
    // rising edge that consumed them, when the registered outputs are stable.
    task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic f);
        @(negedge clk);
        data_in  = d;
        valid_in = v;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset    = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] lane_exp [5];
        logic [W-1:0] lane_words [5];

        checks   = 0;
        fails    = 0;
        reset    = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("rst_lane_data",   lane_data,   0);
        checkOutput("rst_lane_valid",  lane_valid,  0);
        checkOutput("rst_lane_cnt",    lane_cnt,    0);
        checkOutput("rst_frame_data",  frame_data,  0);
        checkOutput("rst_frame_valid", frame_valid, 0);
        checkOutput("rst_frame_cnt",   frame_cnt,   0);

        $display("[TB] frame mode back-to-back frame");
        applyStimulus(8'hA0, 1'b1, 1'b0);
        applyStimulus(8'hA1, 1'b1, 1'b0);
        applyStimulus(8'hA2, 1'b1, 1'b0);
        checkOutput("b2b_no_early_valid", frame_valid, 0);
        applyStimulus(8'hA3, 1'b1, 1'b0);
        checkOutput("b2b_data",  frame_data,  32'hA3A2A1A0);
        checkOutput("b2b_valid", frame_valid, 4'b1111);
        checkOutput("b2b_cnt",   frame_cnt,   1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("b2b_valid_drops", frame_valid, 0);

        $display("[TB] lane mode sequence");
        resetDut();
        lane_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        lane_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(lane_words[i], 1'b1, 1'b0);
            checkOutput($sformatf("lane_valid_%0d", i), lane_valid, lane_exp[i]);
            if (i == 3) begin
                checkOutput("lane_frame_data_at_4", frame_data, 32'h44332211);
            end
        end
        checkOutput("lane_data", lane_data, 32'h44332255);
        checkOutput("lane_cnt",  lane_cnt,  1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("lane_valid_idle", lane_valid, 0);

        $display("[TB] frame mode partial flush");
        resetDut();
        applyStimulus(8'hB0, 1'b1, 1'b0);
        applyStimulus(8'hB1, 1'b1, 1'b0);
        applyStimulus(8'hB2, 1'b1, 1'b1);
        checkOutput("pflush_valid",     frame_valid, 4'b0111);
        checkOutput("pflush_data",      frame_data,  32'h00B2B1B0);
        checkOutput("pflush_cnt",       frame_cnt,   1);
        checkOutput("pflush_lane_valid", lane_valid, 4'b0100);
        checkOutput("pflush_lane_cnt",   lane_cnt,   1);
        applyStimulus(8'hC0, 1'b1, 1'b0);
        applyStimulus(8'hC1, 1'b1, 1'b0);
        applyStimulus(8'hC2, 1'b1, 1'b0);
        applyStimulus(8'hC3, 1'b1, 1'b0);
        checkOutput("realign_data",  frame_data,  32'hC3C2C1C0);
        checkOutput("realign_valid", frame_valid, 4'b1111);
        checkOutput("realign_cnt",   frame_cnt,   2);

        $display("[TB] gaps and empty flush");
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(8'hD0 + i), 1'b1, 1'b0);
            if (i < 3) begin
                repeat (3) applyStimulus(8'h00, 1'b0, 1'b0);
                checkOutput($sformatf("gap_valid_%0d", i), frame_valid, 0);
            end
        end
        checkOutput("gap_data",  frame_data,  32'hD3D2D1D0);
        checkOutput("gap_valid", frame_valid, 4'b1111);
        checkOutput("gap_cnt",   frame_cnt,   1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("eflush_valid",    frame_valid, 0);
        checkOutput("eflush_cnt",      frame_cnt,   1);
        checkOutput("eflush_lane_cnt", lane_cnt,    1);

        $display("[TB] full frame with flush, then one-word flush");
        applyStimulus(8'hE0, 1'b1, 1'b0);
        applyStimulus(8'hE1, 1'b1, 1'b0);
        applyStimulus(8'hE2, 1'b1, 1'b0);
        applyStimulus(8'hE3, 1'b1, 1'b1);
        checkOutput("fullflush_valid", frame_valid, 4'b1111);
        checkOutput("fullflush_cnt",   frame_cnt,   2);
        checkOutput("fullflush_lane_cnt", lane_cnt, 2);
        applyStimulus(8'hF0, 1'b1, 1'b1);
        checkOutput("oneword_valid", frame_valid, 4'b0001);
        checkOutput("oneword_data",  frame_data,  32'hE3E2E1F0);
        checkOutput("oneword_cnt",   frame_cnt,   3);
        checkOutput("oneword_lane_cnt", lane_cnt, 3);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h60, 1'b1, 1'b0);
        applyStimulus(8'h61, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_data",  frame_data,  0);
        checkOutput("async_rst_valid", frame_valid, 0);
        checkOutput("async_rst_cnt",   frame_cnt,   0);
        checkOutput("async_rst_lane_data", lane_data, 0);
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h70, 1'b1, 1'b0);
        applyStimulus(8'h71, 1'b1, 1'b0);
        applyStimulus(8'h72, 1'b1, 1'b0);
        applyStimulus(8'h73, 1'b1, 1'b0);
        checkOutput("post_rst_data",  frame_data,  32'h73727170);
        checkOutput("post_rst_valid", frame_valid, 4'b1111);
        checkOutput("post_rst_cnt",   frame_cnt,   1);

        $display("[TB] frame counter wrap");
        resetDut();
        for (int i = 0; i < 17; i++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus(8'(i * 4 + j), 1'b1, 1'b0);
            end
            if (i == 15) begin
                checkOutput("wrap_cnt_16", wrap_cnt, 0);
            end
        end
        checkOutput("wrap_cnt_17",  wrap_cnt,  1);
        checkOutput("wrap_data_17", wrap_data, 32'h43424140);
        checkOutput("wide_cnt_17",  frame_cnt, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
